// File: rtl/mem_sync.sv
// Single-port synchronous RAM with a valid/ready request port, registered read path of
// READ_LAT (1 or 2) cycles, byte-masked writes and a post-reset clear sequencer. Optional parity: MEM_PARITY_EN.
module mem_sync #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 16,
  parameter int DEPTH    = 256,
  parameter int READ_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [DATA_W/8-1:0]   req_wmask,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_addr_err,
  output logic                  rsp_perr,
  output logic                  init_busy,
  output logic                  wr_addr_err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NB    = DATA_W / 8;
  localparam logic [0:0]        ST_INIT  = 1'b0;
  localparam logic [0:0]        ST_RUN   = 1'b1;
  localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W+1)'(DEPTH);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);

  logic [0:0]        state;
  logic [IDX_W-1:0]  clr_ptr;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              acc, rd_acc, wr_acc, in_range, rd_perr;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] cur_word, wr_merged;

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // req_ready is high in every RUN cycle and low while the clear sequence runs.
  assign req_ready = (state == ST_RUN);
  assign init_busy = (state == ST_INIT);
  assign acc       = req_valid & req_ready;
  assign rd_acc    = acc & ~req_we;
  assign wr_acc    = acc & req_we;
  assign in_range  = {1'b0, req_addr} < DEPTH_X;
  assign idx       = req_addr[IDX_W-1:0];
  assign cur_word  = mem[idx];

  always_comb begin
    wr_merged = cur_word;
    for (int b = 0; b < NB; b++) begin
      if (req_wmask[b]) wr_merged[8*b +: 8] = req_wdata[8*b +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_INIT;
      clr_ptr <= '0;
    end else if (state == ST_INIT) begin
      if (clr_ptr == LAST_IDX) state <= ST_RUN;
      clr_ptr <= clr_ptr + 1'b1;
    end
  end

`ifdef MEM_PARITY_EN
  logic par [DEPTH];
  assign rd_perr = (^cur_word) ^ par[idx];

  always_ff @(posedge clk) begin
    if (state == ST_INIT) begin
      par[clr_ptr] <= 1'b0;
    end else if (wr_acc && in_range) begin
      par[idx] <= ^wr_merged;
    end
  end
`else
  assign rd_perr = 1'b0;
`endif

  // Storage is not reset; the clear sequencer defines every word before RUN.
  always_ff @(posedge clk) begin
    if (state == ST_INIT) begin
      mem[clr_ptr] <= '0;
    end else if (wr_acc && in_range) begin
      mem[idx] <= wr_merged;
    end
  end

  logic              p1_valid, p1_err, p1_perr;
  logic [DATA_W-1:0] p1_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_valid    <= 1'b0;
      p1_rdata    <= '0;
      p1_err      <= 1'b0;
      p1_perr     <= 1'b0;
      wr_addr_err <= 1'b0;
    end else begin
      p1_valid    <= rd_acc;
      wr_addr_err <= wr_acc & ~in_range;
      if (rd_acc) begin
        p1_rdata <= in_range ? cur_word : '0;
        p1_err   <= ~in_range;
        p1_perr  <= in_range & rd_perr;
      end
    end
  end

  generate
    if (READ_LAT == 2) begin : g_lat2
      logic              p2_valid, p2_err, p2_perr;
      logic [DATA_W-1:0] p2_rdata;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          p2_valid <= 1'b0;
          p2_rdata <= '0;
          p2_err   <= 1'b0;
          p2_perr  <= 1'b0;
        end else begin
          p2_valid <= p1_valid;
          if (p1_valid) begin
            p2_rdata <= p1_rdata;
            p2_err   <= p1_err;
            p2_perr  <= p1_perr;
          end
        end
      end

      assign rsp_valid    = p2_valid;
      assign rsp_rdata    = p2_rdata;
      assign rsp_addr_err = p2_err;
      assign rsp_perr     = p2_perr;
    end else begin : g_lat1
      assign rsp_valid    = p1_valid;
      assign rsp_rdata    = p1_rdata;
      assign rsp_addr_err = p1_err;
      assign rsp_perr     = p1_perr;
    end
  endgenerate

endmodule

// File: tb/tb_mem_sync.sv
// Bench for mem_sync: directed cases plus random traffic checked against an array model
// of memory contents and a queue of expected responses with their arrival cycles.
module tb_mem_sync;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 16;
  localparam int DEPTH    = 256;
  localparam int READ_LAT = 1;
  localparam int W        = DATA_W + 2;

  logic              clk, rst_n;
  logic              req_valid, req_ready, req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [1:0]        req_wmask;
  logic              rsp_valid, rsp_addr_err, rsp_perr, init_busy, wr_addr_err;
  logic [DATA_W-1:0] rsp_rdata;

  mem_sync #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .READ_LAT(READ_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_addr_err(rsp_addr_err),
    .rsp_perr(rsp_perr), .init_busy(init_busy), .wr_addr_err(wr_addr_err)
  );

  // ---------------- clock / reset ----------------
  int cyc = 0;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0]      exp_q[$];
  int                exp_cyc_q[$];
  int                werr_q[$];
  logic [DATA_W-1:0] model_mem [DEPTH];
  bit                model_bad [DEPTH];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      model_mem[i] = '0;
      model_bad[i] = 1'b0;
    end
    exp_q.delete();
    exp_cyc_q.delete();
    werr_q.delete();
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          check_eq("rsp_unexpected", 1, 0);
        end else begin
          logic [W-1:0] e;
          int ec;
          e  = exp_q.pop_front();
          ec = exp_cyc_q.pop_front();
          check_eq("rsp_rdata", rsp_rdata, e[DATA_W-1:0]);
          check_eq("rsp_addr_err", rsp_addr_err, e[DATA_W]);
          check_eq("rsp_perr", rsp_perr, e[DATA_W+1]);
          check_eq("rsp_cycle", cyc, ec);
        end
      end else if (exp_cyc_q.size() > 0 && exp_cyc_q[0] <= cyc) begin
        check_eq("rsp_missing", 0, 1);
        void'(exp_q.pop_front());
        void'(exp_cyc_q.pop_front());
      end
      if (wr_addr_err) begin
        if (werr_q.size() == 0) check_eq("wr_err_unexpected", 1, 0);
        else check_eq("wr_err_cycle", cyc, werr_q.pop_front());
      end else if (werr_q.size() > 0 && werr_q[0] <= cyc) begin
        check_eq("wr_err_missing", 0, 1);
        void'(werr_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle();
    @(negedge clk);
    req_valid = 1'b0;
    req_we    = 1'b0;
  endtask

  task automatic drain();
    repeat (READ_LAT + 3) idle();
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                          input logic [1:0] mask);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = addr; req_wdata = data; req_wmask = mask;
    if (addr < DEPTH) begin
      for (int b = 0; b < 2; b++)
        if (mask[b]) model_mem[addr][8*b +: 8] = data[8*b +: 8];
      model_bad[addr] = 1'b0;
    end else begin
      werr_q.push_back(cyc + 1);
    end
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] addr);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = addr;
    req_wdata = DATA_W'($urandom); req_wmask = 2'($urandom);
    if (addr < DEPTH) exp_q.push_back({model_bad[addr], 1'b0, model_mem[addr]});
    else              exp_q.push_back({1'b0, 1'b1, {DATA_W{1'b0}}});
    exp_cyc_q.push_back(cyc + READ_LAT);
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_rsp_rdata", rsp_rdata, 0);
    check_eq("rst_rsp_addr_err", rsp_addr_err, 0);
    check_eq("rst_rsp_perr", rsp_perr, 0);
    check_eq("rst_wr_addr_err", wr_addr_err, 0);
    check_eq("rst_req_ready", req_ready, 0);
    check_eq("rst_init_busy", init_busy, 1);
  endtask

  task automatic release_and_init();
    int n;
    int bad;
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    bad = 0;
    while (init_busy && n < 4 * DEPTH) begin
      if (req_ready) bad++;
      @(negedge clk);
      n++;
    end
    check_eq("init_cycles", n, DEPTH);
    check_eq("init_ready_low", bad, 0);
    check_eq("run_req_ready", req_ready, 1);
    check_eq("run_init_busy", init_busy, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    req_addr = '0; req_wdata = '0; req_wmask = '0;
    model_clear();
    repeat (3) @(negedge clk);
    check_reset_outputs();
    release_and_init();

    // Fresh memory reads zero
    do_read(16'h00FF);
    drain();

    // Full write then immediate read
    do_write(16'd5, 16'hBEEF, 2'b11);
    do_read(16'd5);
    drain();

    // Byte-masked merge
    do_write(16'd7, 16'h1234, 2'b11);
    do_write(16'd7, 16'hAB00, 2'b10);
    do_write(16'd7, 16'hFFFF, 2'b00);
    do_read(16'd7);
    drain();
    check_eq("rdata_hold", rsp_rdata, 16'hAB34);

    // Out-of-range accesses
    do_read(16'h0100);
    do_write(16'h0100, 16'hFFFF, 2'b11);
    do_read(16'h0000);
    do_read(16'h00FF);
    do_read(16'hFFFF);
    do_write(16'hFFFF, 16'h5555, 2'b01);
    drain();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      int sel;
      logic [ADDR_W-1:0] a;
      sel = $urandom_range(0, 99);
      if (sel < 70)      a = ADDR_W'($urandom_range(0, 15));
      else if (sel < 85) a = ADDR_W'($urandom_range(DEPTH - 6, DEPTH - 1));
      else if (sel < 93) a = ADDR_W'($urandom_range(0, DEPTH - 1));
      else               a = ADDR_W'($urandom_range(DEPTH, 65535));
      case ($urandom_range(0, 4))
        0, 1:    do_read(a);
        2, 3:    do_write(a, DATA_W'($urandom), 2'($urandom));
        default: idle();
      endcase
    end
    drain();

    // Reset while reads are in flight
    do_read(16'd1);
    do_read(16'd2);
    do_read(16'd3);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    req_valid = 1'b0;
    model_clear();
    @(negedge clk);
    check_reset_outputs();
    release_and_init();
    do_read(16'd1);
    do_read(16'd5);
    drain();

`ifdef MEM_PARITY_EN
    do_write(16'd3, 16'h0001, 2'b11);
    idle();
    dut.mem[3] = dut.mem[3] ^ 16'h0004;
    model_mem[3] = model_mem[3] ^ 16'h0004;
    model_bad[3] = 1'b1;
    do_read(16'd3);
    do_write(16'd4, 16'h0003, 2'b11);
    do_read(16'd4);
    drain();
`endif

    check_eq("exp_q_empty", exp_q.size(), 0);
    check_eq("werr_q_empty", werr_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

endmodule
